// File: rtl/pcm_pkg.sv
// Shared constants, state encoding and address helper for the pixel collision map.
// The map mirrors a 160x120 VGA plot stream, one occupancy bit per pixel.
package pcm_pkg;

   localparam int SCREEN_W  = 160;
   localparam int SCREEN_H  = 120;
   localparam int BOX       = 8;
   localparam int MAP_DEPTH = 19200;

   localparam logic [2:0] ST_CLEAR = 3'd0;
   localparam logic [2:0] ST_IDLE  = 3'd1;
   localparam logic [2:0] ST_SCAN  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // y*160 + x built from two shifts so no multiplier is inferred.
   function automatic logic [14:0] pixAddr(input logic [6:0] y, input logic [7:0] x);
      logic [14:0] yw;
      yw = {8'd0, y};
      return (yw << 7) + (yw << 5) + {7'd0, x};
   endfunction

endpackage

// File: rtl/pcm_occ_ram.sv
// 19200x1 simple dual-port occupancy store with a registered read port.
// A same-cycle write and read of one address returns the old bit.
module pcm_occ_ram
   import pcm_pkg::*;
(
   input  logic        clk,
   input  logic        i_we,
   input  logic [14:0] i_waddr,
   input  logic        i_wdata,
   input  logic [14:0] i_raddr,
   output logic        o_rdata
);

   logic r_mem [0:MAP_DEPTH-1];

   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_waddr] <= i_wdata;
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/pixel_collision_map.sv
// Shadows the obstacle plot stream into an occupancy map and answers
// "is anything drawn inside this 8x8 box" queries with a 64-cycle scan.
module pixel_collision_map
   import pcm_pkg::*;
(
   input  logic       CLOCK,
   input  logic       resetn,
   input  logic [7:0] x,
   input  logic [6:0] y,
   input  logic [2:0] colour,
   input  logic       writeEn,
   input  logic [7:0] qx,
   input  logic [6:0] qy,
   input  logic       query_req,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic       hit
);

   logic [2:0]  r_state;
   logic [14:0] r_clrAddr;
   logic [7:0]  r_qx;
   logic [6:0]  r_qy;
   logic [2:0]  r_cx;
   logic [2:0]  r_cy;
   logic        r_acc;
   logic        r_rdPend;
   logic        r_rdValid;
   logic        r_done;
   logic        r_hit;

   logic [8:0]  w_sx;
   logic [7:0]  w_sy;
   logic        w_inRange;
   logic        w_plotOk;
   logic        w_we;
   logic [14:0] w_waddr;
   logic        w_wdata;
   logic [14:0] w_raddr;
   logic        w_rdata;

   // Sums are one bit wider than the inputs so off-screen pixels never alias back on-screen.
   assign w_sx      = {1'b0, r_qx} + {6'd0, r_cx};
   assign w_sy      = {1'b0, r_qy} + {5'd0, r_cy};
   assign w_inRange = (w_sx < 9'(SCREEN_W)) && (w_sy < 8'(SCREEN_H));
   assign w_raddr   = w_inRange ? pixAddr(w_sy[6:0], w_sx[7:0]) : 15'd0;

   assign ready    = (r_state != ST_CLEAR);
   assign busy     = (r_state != ST_IDLE);
   assign done     = r_done;
   assign hit      = r_hit;

   assign w_plotOk = writeEn && ready && (x < 8'(SCREEN_W)) && (y < 7'(SCREEN_H));

   // The clear sweep owns the write port; afterwards the plot stream does.
   always_comb begin
      w_we    = w_plotOk;
      w_waddr = pixAddr(y, x);
      w_wdata = (colour != 3'd0);
      if (r_state == ST_CLEAR) begin
         w_we    = 1'b1;
         w_waddr = r_clrAddr;
         w_wdata = 1'b0;
      end
   end

   pcm_occ_ram u_ram (
      .clk     (CLOCK),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge CLOCK) begin
      if (!resetn) begin
         r_state   <= ST_CLEAR;
         r_clrAddr <= 15'd0;
         r_qx      <= 8'd0;
         r_qy      <= 7'd0;
         r_cx      <= 3'd0;
         r_cy      <= 3'd0;
         r_acc     <= 1'b0;
         r_rdPend  <= 1'b0;
         r_rdValid <= 1'b0;
         r_done    <= 1'b0;
         r_hit     <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_rdPend  <= (r_state == ST_SCAN);
         r_rdValid <= w_inRange;
         if (r_rdPend)
            r_acc <= r_acc | (w_rdata & r_rdValid);
         case (r_state)
            ST_CLEAR: begin
               if (r_clrAddr == 15'(MAP_DEPTH - 1))
                  r_state <= ST_IDLE;
               else
                  r_clrAddr <= r_clrAddr + 15'd1;
            end
            ST_IDLE: begin
               if (query_req) begin
                  r_qx    <= qx;
                  r_qy    <= qy;
                  r_cx    <= 3'd0;
                  r_cy    <= 3'd0;
                  r_acc   <= 1'b0;
                  r_state <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               r_cx <= r_cx + 3'd1;
               if (r_cx == 3'(BOX - 1)) begin
                  r_cy <= r_cy + 3'd1;
                  if (r_cy == 3'(BOX - 1))
                     r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: r_state <= ST_DONE;
            ST_DONE: begin
               r_done  <= 1'b1;
               r_hit   <= r_acc;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_collision_map.sv
// Directed bench for pixel_collision_map: clear sweep timing, box queries,
// screen-edge clipping, ignored writes/requests, and reset during a scan.
module tb_pixel_collision_map;

   logic       CLOCK = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] x = 8'd0;
   logic [6:0] y = 7'd0;
   logic [2:0] colour = 3'd0;
   logic       writeEn = 1'b0;
   logic [7:0] qx = 8'd0;
   logic [6:0] qy = 7'd0;
   logic       query_req = 1'b0;
   logic       ready, busy, done, hit;

   int checks = 0;
   int passes = 0;

   pixel_collision_map dut (
      .CLOCK     (CLOCK),
      .resetn    (resetn),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .writeEn   (writeEn),
      .qx        (qx),
      .qy        (qy),
      .query_req (query_req),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .hit       (hit)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic tick;
      @(posedge CLOCK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input int got, input int exp);
      checks++;
      if (got == exp)
         passes++;
      else
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // One plot-stream pixel write.
   task automatic applyStimulus(input logic [7:0] px, input logic [6:0] py, input logic [2:0] c);
      x = px; y = py; colour = c; writeEn = 1'b1;
      tick;
      writeEn = 1'b0;
   endtask

   task automatic plotBox(input logic [7:0] px, input logic [6:0] py, input logic [2:0] c);
      for (int j = 0; j < 8; j++)
         for (int i = 0; i < 8; i++)
            applyStimulus(px + 8'(i), py + 7'(j), c);
   endtask

   // Called right after the reset edge; walks the whole clear sweep.
   task automatic sweepClear(input string tag);
      int readyHigh = 0;
      int donePulses = 0;
      checkOutput({tag, "_resetReady"}, ready, 0);
      checkOutput({tag, "_resetBusy"}, busy, 1);
      checkOutput({tag, "_resetDone"}, done, 0);
      checkOutput({tag, "_resetHit"}, hit, 0);
      for (int i = 1; i < 19200; i++) begin
         tick;
         if (ready) readyHigh++;
         if (done) donePulses++;
      end
      checkOutput({tag, "_readyHighDuringClear"}, readyHigh, 0);
      checkOutput({tag, "_doneDuringClear"}, donePulses, 0);
      tick;
      checkOutput({tag, "_readyAfterClear"}, ready, 1);
      checkOutput({tag, "_idleBusy"}, busy, 0);
   endtask

   // Issues a query; optionally pulses query_req or plots (wx,wy) at scan cycle injQ/injW.
   task automatic runQuery(input logic [7:0] ax, input logic [6:0] ay,
                           input int injQ, input int injW,
                           input logic [7:0] wx, input logic [6:0] wy,
                           output logic h, output int lat);
      qx = ax; qy = ay; query_req = 1'b1;
      tick;
      query_req = 1'b0;
      lat = 0;
      while (lat < 200) begin
         query_req = (lat == injQ);
         if (lat == injW) begin
            x = wx; y = wy; colour = 3'd1; writeEn = 1'b1;
         end
         tick;
         lat++;
         query_req = 1'b0;
         writeEn = 1'b0;
         if (done) break;
      end
      h = hit;
   endtask

   task automatic query(input string tag, input logic [7:0] ax, input logic [6:0] ay, input int expHit);
      logic h;
      int   lat;
      runQuery(ax, ay, -1, -1, 8'd0, 7'd0, h, lat);
      checkOutput({tag, "_latency"}, lat, 66);
      checkOutput({tag, "_hit"}, h, expHit);
   endtask

   initial begin
      logic h;
      int   lat;
      int   extraDone;

      tick;
      tick;
      resetn = 1'b1;
      sweepClear("por");

      query("emptyOrigin", 8'd0, 7'd0, 0);
      tick;
      checkOutput("donePulseWidth", done, 0);

      plotBox(8'd40, 7'd25, 3'b100);
      query("boxOverlap", 8'd36, 7'd22, 1);
      for (int i = 0; i < 5; i++) tick;
      checkOutput("hitHoldsAfterDone", hit, 1);
      query("boxRightMiss", 8'd48, 7'd25, 0);
      query("boxCornerTouch", 8'd33, 7'd18, 1);
      query("boxCornerMiss", 8'd32, 7'd17, 0);

      plotBox(8'd40, 7'd25, 3'b000);
      query("boxErased", 8'd40, 7'd25, 0);

      applyStimulus(8'd159, 7'd119, 3'd1);
      query("edgeBox", 8'd156, 7'd116, 1);
      query("edgeNoWrap", 8'd158, 7'd118, 1);
      applyStimulus(8'd159, 7'd119, 3'd0);
      applyStimulus(8'd0, 7'd0, 3'd2);
      query("cornerNoWrapToOrigin", 8'd159, 7'd119, 0);
      query("xSumNoWrap", 8'd250, 7'd0, 0);
      query("ySumNoWrap", 8'd0, 7'd125, 0);
      query("originSet", 8'd0, 7'd0, 1);

      // x=200,y=10 would alias to pixel (40,11) if not rejected.
      applyStimulus(8'd200, 7'd10, 3'd7);
      query("offscreenWriteIgnored", 8'd36, 7'd8, 0);

      // Plot (60,60) in the same cycle the scan reads it, and re-request mid-scan.
      runQuery(8'd60, 7'd60, 20, 0, 8'd60, 7'd60, h, lat);
      checkOutput("collisionLatency", lat, 66);
      checkOutput("collisionReadsOld", h, 0);
      extraDone = 0;
      for (int i = 0; i < 80; i++) begin
         tick;
         if (done) extraDone++;
      end
      checkOutput("scanRequestIgnored", extraDone, 0);
      query("writeDuringScanApplied", 8'd60, 7'd60, 1);

      qx = 8'd60; qy = 7'd60; query_req = 1'b1;
      tick;
      query_req = 1'b0;
      for (int i = 0; i < 29; i++) tick;
      checkOutput("scanBusy", busy, 1);
      checkOutput("scanReady", ready, 1);
      resetn = 1'b0;
      tick;
      resetn = 1'b1;
      sweepClear("midScan");
      query("clearedPixel60", 8'd60, 7'd60, 0);
      query("clearedOrigin", 8'd0, 7'd0, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
